// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC capture path: record layout, ASCII framing bytes
// and the hexdump FSM encoding.
package lpc_pkg;

  localparam int REC_W       = 48;
  localparam int ADDR_HI     = 47;
  localparam int ADDR_LO     = 16;
  localparam int DATA_HI     = 15;
  localparam int DATA_LO     = 8;
  localparam int TIMEOUT_BIT = 4;
  localparam int CYCTYPE_HI  = 3;
  localparam int CYCTYPE_LO  = 0;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } hexdump_state_t;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational nibble-to-ASCII hex digit converter; letter case chosen at build time.
module hex_nibble_ascii #(
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  localparam logic [7:0] ALPHA_BASE = HEX_UPPER ? 8'h41 : 8'h61;

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'd0, nibble};
    end else begin
      ascii = ALPHA_BASE + {4'd0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/lpc_record_hexdump.sv
// Pops one 48-bit LPC record from the ringbuffer and streams it to the byte
// transmitter as a 16-character ASCII line "AAAAAAAA DD SS\r\n".
module lpc_record_hexdump
  import lpc_pkg::*;
#(
  parameter bit HEX_UPPER    = 1'b1,
  parameter bit SKIP_TIMEOUT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             read_empty,
  input  logic [REC_W-1:0] read_data,
  output logic             read_clock_enable,
  input  logic             uart_ready,
  output logic             uart_clock_enable,
  output logic [7:0]       uart_data,
  output logic             busy,
  output logic [15:0]      dropped
);

  hexdump_state_t   state_reg, state_next;
  logic [REC_W-1:0] record_reg;
  logic [3:0]       index_reg;
  logic [15:0]      dropped_reg;
  logic [7:0]       uart_data_reg;
  logic [7:0]       digit_ascii [12];
  logic [7:0]       byte_mux;
  logic             discard;

  // The record is exactly 12 nibbles: 8 addr, 2 data, 2 status, MSB first.
  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_digit
      hex_nibble_ascii #(.HEX_UPPER(HEX_UPPER)) u_hex (
        .nibble (record_reg[REC_W-1-4*gi -: 4]),
        .ascii  (digit_ascii[gi])
      );
    end
  endgenerate

  assign discard = SKIP_TIMEOUT && record_reg[TIMEOUT_BIT];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (!read_empty) state_next = ST_POP;
      ST_POP:  state_next = discard ? ST_IDLE : ST_SEND;
      ST_SEND: if (uart_ready) state_next = ST_GAP;
      ST_GAP:  state_next = (index_reg == 4'd15) ? ST_IDLE : ST_SEND;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    read_clock_enable = (state_reg == ST_POP);
    uart_clock_enable = (state_reg == ST_SEND) && uart_ready;
    busy              = (state_reg != ST_IDLE);
  end

  always_comb begin
    byte_mux = 8'h00;
    case (index_reg)
      4'd8, 4'd11: byte_mux = ASCII_SPACE;
      4'd9:        byte_mux = digit_ascii[8];
      4'd10:       byte_mux = digit_ascii[9];
      4'd12:       byte_mux = digit_ascii[10];
      4'd13:       byte_mux = digit_ascii[11];
      4'd14:       byte_mux = ASCII_CR;
      4'd15:       byte_mux = ASCII_LF;
      default:     byte_mux = digit_ascii[index_reg[2:0]];
    endcase
  end

  // Byte is presented combinationally with its strobe, then held afterwards.
  assign uart_data = uart_clock_enable ? byte_mux : uart_data_reg;
  assign dropped   = dropped_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      record_reg    <= '0;
      index_reg     <= '0;
      dropped_reg   <= '0;
      uart_data_reg <= '0;
    end else begin
      if (state_reg == ST_IDLE && !read_empty) begin
        record_reg <= read_data;
      end
      if (state_reg == ST_POP) begin
        index_reg <= '0;
      end else if (state_reg == ST_GAP) begin
        index_reg <= index_reg + 4'd1;
      end
      if (state_reg == ST_POP && discard && dropped_reg != 16'hFFFF) begin
        dropped_reg <= dropped_reg + 16'd1;
      end
      if (uart_clock_enable) begin
        uart_data_reg <= byte_mux;
      end
    end
  end

endmodule

// File: tb/tb_lpc_record_hexdump.sv
// Directed bench: a small ringbuffer model and a byte capture monitor around three
// instances (upper-case, lower-case, upper-case with timeout skipping).
module tb_lpc_record_hexdump;

  logic        clock = 1'b0;
  logic        reset;
  logic        uart_ready;
  logic [47:0] read_data;
  logic        read_empty [3];
  logic        rce [3];
  logic        uce [3];
  logic [7:0]  ud [3];
  logic        bsy [3];
  logic [15:0] drp [3];

  int          sel = 0;
  logic [47:0] rb_mem [16];
  int          rb_head = 0;
  int          rb_tail = 0;

  int          cyc_count = 0;
  int          cap_n = 0;
  int          pop_total = 0;
  int          viol_ready = 0;
  int          viol_gap = 0;
  int          viol_empty = 0;
  logic        prev_uce = 1'b0;
  logic [7:0]  cap_bytes [512];
  int          cap_cyc [512];

  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clock = ~clock;

  assign read_data = rb_mem[rb_head[3:0]];
  for (genvar gi = 0; gi < 3; gi++) begin : g_empty
    assign read_empty[gi] = (sel != gi) || (rb_head == rb_tail);
  end

  lpc_record_hexdump #(.HEX_UPPER(1'b1), .SKIP_TIMEOUT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .read_empty(read_empty[0]), .read_data(read_data),
    .read_clock_enable(rce[0]), .uart_ready(uart_ready), .uart_clock_enable(uce[0]),
    .uart_data(ud[0]), .busy(bsy[0]), .dropped(drp[0]));

  lpc_record_hexdump #(.HEX_UPPER(1'b0), .SKIP_TIMEOUT(1'b0)) dut1 (
    .clock(clock), .reset(reset), .read_empty(read_empty[1]), .read_data(read_data),
    .read_clock_enable(rce[1]), .uart_ready(uart_ready), .uart_clock_enable(uce[1]),
    .uart_data(ud[1]), .busy(bsy[1]), .dropped(drp[1]));

  lpc_record_hexdump #(.HEX_UPPER(1'b1), .SKIP_TIMEOUT(1'b1)) dut2 (
    .clock(clock), .reset(reset), .read_empty(read_empty[2]), .read_data(read_data),
    .read_clock_enable(rce[2]), .uart_ready(uart_ready), .uart_clock_enable(uce[2]),
    .uart_data(ud[2]), .busy(bsy[2]), .dropped(drp[2]));

  // Mid-cycle monitor: captures strobed bytes, performs ringbuffer pops, flags protocol breaks.
  always @(negedge clock) begin
    cyc_count <= cyc_count + 1;
    prev_uce  <= uce[sel];
    if (uce[sel] === 1'b1) begin
      cap_bytes[cap_n[8:0]] <= ud[sel];
      cap_cyc[cap_n[8:0]]   <= cyc_count + 1;
      cap_n                 <= cap_n + 1;
      if (uart_ready !== 1'b1) viol_ready <= viol_ready + 1;
      if (prev_uce === 1'b1) viol_gap <= viol_gap + 1;
    end
    if (rce[sel] === 1'b1) begin
      pop_total <= pop_total + 1;
      if (rb_head == rb_tail) viol_empty <= viol_empty + 1;
      else rb_head <= rb_head + 1;
    end
  end

  task automatic push_rec(input logic [47:0] rec);
    rb_mem[rb_tail[3:0]] = rec;
    rb_tail = rb_tail + 1;
  endtask

  task automatic wait_done(input int max_cycles, input bit stall, output bit timed_out);
    int last_n;
    int stall_left;
    last_n = cap_n;
    stall_left = 0;
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge clock); #1;
      if (stall) begin
        if (cap_n != last_n) begin
          last_n = cap_n;
          stall_left = $urandom_range(0, 7);
        end
        if (stall_left > 0) begin
          uart_ready = 1'b0;
          stall_left--;
        end else begin
          uart_ready = 1'b1;
        end
      end
      if (rb_head == rb_tail && bsy[sel] === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
    uart_ready = 1'b1;
  endtask

  function automatic string cap_str(input int base, input int n);
    string s;
    s = "";
    for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, cap_bytes[(base + i) % 512]);
    return s;
  endfunction

  function automatic string shown(input string s);
    string r;
    byte c;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h0D) r = {r, "\\r"};
      else if (c == 8'h0A) r = {r, "\\n"};
      else if (c < 8'h20 || c > 8'h7E) r = {r, $sformatf("<%02h>", c)};
      else r = $sformatf("%s%c", r, c);
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (rce[k] !== 1'b0 || uce[k] !== 1'b0 || ud[k] !== 8'h00 || bsy[k] !== 1'b0 || drp[k] !== 16'h0000) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs[%0d]: rce=%b uce=%b data=%h busy=%b dropped=%h, required 0 0 00 0 0000",
                 k, rce[k], uce[k], ud[k], bsy[k], drp[k]);
      end
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_single_line();
    string exp_s, got;
    int base, p0, push_cyc;
    bit to;
    sel = 0;
    base = cap_n; p0 = pop_total;
    push_rec(48'h00000080_34_02);
    push_cyc = cyc_count;
    wait_done(200, 1'b0, to);
    got = cap_str(base, cap_n - base);
    exp_s = "00000080 34 02\r\n";
    $display("[TB] single line: %s", shown(got));
    tests_run++;
    if (to) begin tests_failed++; $display("[TB] FAIL single_timeout: got no completion, required idle within 200 cycles"); end
    tests_run++;
    if (got != exp_s) begin tests_failed++; $display("[TB] FAIL single_text: got '%s', required '%s'", shown(got), shown(exp_s)); end
    tests_run++;
    if (pop_total - p0 !== 1) begin tests_failed++; $display("[TB] FAIL single_pops: got %0d, required 1", pop_total - p0); end
    tests_run++;
    if (cap_cyc[base % 512] - push_cyc !== 3) begin
      tests_failed++; $display("[TB] FAIL single_latency: got %0d, required 3", cap_cyc[base % 512] - push_cyc);
    end
    tests_run++;
    if (cap_cyc[(base + 15) % 512] - cap_cyc[base % 512] !== 30) begin
      tests_failed++; $display("[TB] FAIL single_line_span: got %0d, required 30", cap_cyc[(base + 15) % 512] - cap_cyc[base % 512]);
    end
  endtask

  task automatic test_hex_case();
    string exp_s [2];
    string got;
    int base;
    bit to;
    exp_s[0] = "DEADBEEF A5 1F\r\n";
    exp_s[1] = "deadbeef a5 1f\r\n";
    for (int k = 1; k >= 0; k--) begin
      sel = k;
      base = cap_n;
      push_rec(48'hDEADBEEF_A5_1F);
      wait_done(200, 1'b0, to);
      got = cap_str(base, cap_n - base);
      $display("[TB] hex case upper=%0d: %s", (k == 0), shown(got));
      tests_run++;
      if (to || got != exp_s[k]) begin
        tests_failed++;
        $display("[TB] FAIL hex_case[%0d]: got '%s' timeout=%0d, required '%s'", k, shown(got), to, shown(exp_s[k]));
      end
    end
    sel = 0;
  endtask

  task automatic test_stall();
    string exp_s, got;
    int base, p0, vr0, vg0;
    bit to;
    sel = 0;
    base = cap_n; p0 = pop_total; vr0 = viol_ready; vg0 = viol_gap;
    uart_ready = 1'b0;
    push_rec(48'h00000080_34_02);
    wait_done(1000, 1'b1, to);
    got = cap_str(base, cap_n - base);
    exp_s = "00000080 34 02\r\n";
    $display("[TB] stalled line: %s", shown(got));
    tests_run++;
    if (to || got != exp_s) begin
      tests_failed++; $display("[TB] FAIL stall_text: got '%s' timeout=%0d, required '%s'", shown(got), to, shown(exp_s));
    end
    tests_run++;
    if (viol_ready - vr0 !== 0) begin tests_failed++; $display("[TB] FAIL stall_strobe_not_ready: got %0d, required 0", viol_ready - vr0); end
    tests_run++;
    if (viol_gap - vg0 !== 0) begin tests_failed++; $display("[TB] FAIL stall_gap: got %0d adjacent strobes, required 0", viol_gap - vg0); end
    tests_run++;
    if (pop_total - p0 !== 1) begin tests_failed++; $display("[TB] FAIL stall_pops: got %0d, required 1", pop_total - p0); end
  endtask

  task automatic test_back_to_back();
    string exp_s, got;
    int base, p0, ve0;
    bit to;
    sel = 0;
    base = cap_n; p0 = pop_total; ve0 = viol_empty;
    push_rec({32'h000003F9, 8'h41, 8'h04});
    push_rec({32'h00000080, 8'h12, 8'h02});
    push_rec({32'h0000002E, 8'hFF, 8'h14});
    wait_done(500, 1'b0, to);
    repeat (10) @(posedge clock);
    #1;
    got = cap_str(base, cap_n - base);
    exp_s = "000003F9 41 04\r\n00000080 12 02\r\n0000002E FF 14\r\n";
    $display("[TB] back-to-back: %s", shown(got));
    tests_run++;
    if (to || got != exp_s) begin
      tests_failed++; $display("[TB] FAIL b2b_text: got '%s' timeout=%0d, required '%s'", shown(got), to, shown(exp_s));
    end
    tests_run++;
    if (pop_total - p0 !== 3) begin tests_failed++; $display("[TB] FAIL b2b_pops: got %0d, required 3", pop_total - p0); end
    tests_run++;
    if (read_empty[0] !== 1'b1 || viol_empty - ve0 !== 0) begin
      tests_failed++; $display("[TB] FAIL b2b_empty: read_empty=%b empty_pops=%0d, required 1 and 0", read_empty[0], viol_empty - ve0);
    end
    tests_run++;
    if (cap_cyc[(base + 16) % 512] - cap_cyc[(base + 15) % 512] !== 4) begin
      tests_failed++; $display("[TB] FAIL b2b_line_gap: got %0d cycles, required 4", cap_cyc[(base + 16) % 512] - cap_cyc[(base + 15) % 512]);
    end
  endtask

  task automatic test_skip_timeout();
    string exp_s, got;
    int base, p0;
    bit to;
    sel = 2;
    base = cap_n; p0 = pop_total;
    push_rec({32'h00000100, 8'hAA, 8'h14});
    push_rec({32'h00000200, 8'hBB, 8'h04});
    wait_done(300, 1'b0, to);
    got = cap_str(base, cap_n - base);
    exp_s = "00000200 BB 04\r\n";
    $display("[TB] skip line: %s dropped=%0d", shown(got), drp[2]);
    tests_run++;
    if (to || got != exp_s) begin
      tests_failed++; $display("[TB] FAIL skip_text: got '%s' timeout=%0d, required '%s'", shown(got), to, shown(exp_s));
    end
    tests_run++;
    if (drp[2] !== 16'd1) begin tests_failed++; $display("[TB] FAIL skip_dropped: got %h, required 0001", drp[2]); end
    tests_run++;
    if (pop_total - p0 !== 2) begin tests_failed++; $display("[TB] FAIL skip_pops: got %0d, required 2", pop_total - p0); end

    force dut2.dropped_reg = 16'hFFFF;
    @(posedge clock); #1;
    release dut2.dropped_reg;
    base = cap_n;
    push_rec({32'h00000300, 8'h77, 8'h1F});
    push_rec({32'h00000400, 8'h5C, 8'h04});
    wait_done(300, 1'b0, to);
    got = cap_str(base, cap_n - base);
    exp_s = "00000400 5C 04\r\n";
    $display("[TB] skip saturate line: %s dropped=%h", shown(got), drp[2]);
    tests_run++;
    if (drp[2] !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL skip_saturate: got %h, required ffff", drp[2]); end
    tests_run++;
    if (to || got != exp_s) begin
      tests_failed++; $display("[TB] FAIL skip_sat_text: got '%s' timeout=%0d, required '%s'", shown(got), to, shown(exp_s));
    end
    sel = 0;
  endtask

  task automatic test_reset_midline();
    string exp_s, got;
    int base;
    bit to;
    sel = 0;
    base = cap_n;
    push_rec(48'h12345678_9A_BC);
    for (int c = 0; c < 200 && cap_n - base < 5; c++) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (rce[0] !== 1'b0 || uce[0] !== 1'b0 || ud[0] !== 8'h00 || bsy[0] !== 1'b0 || drp[0] !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL midline_reset_outputs: rce=%b uce=%b data=%h busy=%b dropped=%h, required 0 0 00 0 0000",
               rce[0], uce[0], ud[0], bsy[0], drp[0]);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    got = cap_str(base, cap_n - base);
    exp_s = "12345";
    $display("[TB] aborted line: %s", shown(got));
    tests_run++;
    if (got != exp_s || ud[0] !== 8'h00 || bsy[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midline_abort: got '%s' data=%h busy=%b, required '%s' 00 0", shown(got), ud[0], bsy[0], exp_s);
    end
    base = cap_n;
    push_rec(48'hCAFE0001_5A_00);
    wait_done(200, 1'b0, to);
    got = cap_str(base, cap_n - base);
    exp_s = "CAFE0001 5A 00\r\n";
    $display("[TB] post-reset line: %s", shown(got));
    tests_run++;
    if (to || got != exp_s) begin
      tests_failed++; $display("[TB] FAIL midline_next: got '%s' timeout=%0d, required '%s'", shown(got), to, shown(exp_s));
    end
  endtask

  initial begin
    reset = 1'b0;
    uart_ready = 1'b1;
    for (int i = 0; i < 16; i++) rb_mem[i] = '0;
    test_reset();
    test_single_line();
    test_hex_case();
    test_stall();
    test_back_to_back();
    test_skip_timeout();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
